// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined small-float multiplier with a single global stall.
// Define FP_MULT_ROUND_EN for round-to-nearest-even; otherwise discarded bits are truncated.
module fp_mult_pipe #(
  parameter  int unsigned EXP_W = 3,
  parameter  int unsigned MAN_W = 4,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         ovf,
  output logic         unf
);

  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned MW = MAN_W + 1;
  localparam int unsigned PW = 2 * MW;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EMIN = EW'(1);

  logic                 advance;
  logic                 s1_valid_q;
  logic [W-1:0]         s1_a_q, s1_b_q;
  logic                 s2_valid_q, s2_sign_q, s2_zero_q;
  logic signed [EW-1:0] s2_esum_q;
  logic [PW-1:0]        s2_prod_q;
  logic                 out_valid_q, ovf_q, unf_q;
  logic [W-1:0]         out_q;

  logic                 s2_sign_d, s2_zero_d;
  logic signed [EW-1:0] s2_esum_d;
  logic [PW-1:0]        s2_prod_d;
  logic [EXP_W-1:0]     ea, eb;
  logic [MW-1:0]        ma, mb;

  logic                 norm, guard, sticky, round_up, carry;
  logic [PW-1:0]        prod_sh;
  logic [MW-1:0]        man_r;
  logic signed [EW-1:0] e_fin;
  logic [W-1:0]         out_d;
  logic                 ovf_d, unf_d;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance || !rst_n;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_a_q     <= a;
      s1_b_q     <= b;
    end
  end

  always_comb begin
    ea        = s1_a_q[W-2 -: EXP_W];
    eb        = s1_b_q[W-2 -: EXP_W];
    ma        = {1'b1, s1_a_q[MAN_W-1:0]};
    mb        = {1'b1, s1_b_q[MAN_W-1:0]};
    s2_sign_d = s1_a_q[W-1] ^ s1_b_q[W-1];
    s2_zero_d = (ea == '0) || (eb == '0);
    s2_esum_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    s2_prod_d = PW'(ma) * PW'(mb);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_esum_q  <= '0;
      s2_prod_q  <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_esum_q  <= s2_esum_d;
      s2_prod_q  <= s2_prod_d;
    end
  end

  // Shift so the leading one always sits at PW-1; mantissa, guard and sticky then have fixed positions.
  always_comb begin
    norm    = s2_prod_q[PW-1];
    prod_sh = norm ? s2_prod_q : (s2_prod_q << 1);
    guard   = prod_sh[MAN_W];
    sticky  = |prod_sh[MAN_W-1:0];
`ifdef FP_MULT_ROUND_EN
    round_up = guard && (sticky || prod_sh[MAN_W+1]);
`else
    round_up = 1'b0 & (guard | sticky);
`endif
    man_r = {1'b0, prod_sh[PW-2 -: MAN_W]} + MW'(round_up);
    carry = man_r[MAN_W];
    e_fin = s2_esum_q + EW'(norm) + EW'(carry);
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s2_zero_q) begin
      out_d = {s2_sign_q, {(W-1){1'b0}}};
    end else if (e_fin > EMAX) begin
      out_d = {s2_sign_q, {(W-1){1'b1}}};
      ovf_d = 1'b1;
    end else if (e_fin < EMIN) begin
      out_d = {s2_sign_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end else begin
      out_d = {s2_sign_q, e_fin[EXP_W-1:0], man_r[MAN_W-1:0]};
    end
  end

  // Result data only changes when a valid result arrives; bubbles leave the last value in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_q <= out_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe at EXP_W=3, MAN_W=4 with hand-computed products.
module tb_fp_mult_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       ovf, unf;

  int unsigned total;
  int unsigned bad;

  fp_mult_pipe #(.EXP_W(3), .MAN_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .ovf      (ovf),
    .unf      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One isolated transaction: accept, then out_valid must appear exactly on the third edge.
  task automatic run_vec(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] eo, input logic eov, input logic eun);
    @(negedge clk);
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    out_ready = 1'b1;
    #1 check_val({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check_val({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check_val({tag, "_lat2"}, out_valid, 0);
    @(negedge clk);
    check_val({tag, "_valid"}, out_valid, 1);
    check_val({tag, "_out"}, out, eo);
    check_val({tag, "_ovf"}, ovf, eov);
    check_val({tag, "_unf"}, unf, eun);
  endtask

  task automatic stream_test;
    logic [7:0] sa [5];
    logic [7:0] sb [5];
    logic [7:0] so [5];
    logic [7:0] held;
    logic       was_stall;
    int unsigned sent, got;
    sa = '{8'h38, 8'hB8, 8'h30, 8'h40, 8'h00};
    sb = '{8'h38, 8'h38, 8'h38, 8'h40, 8'hB8};
    so = '{8'h42, 8'hC2, 8'h38, 8'h50, 8'h80};
    sent = 0;
    got = 0;
    held = '0;
    was_stall = 1'b0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c < 7);
      in_valid  = (sent < 5);
      a         = (sent < 5) ? sa[sent] : 8'h00;
      b         = (sent < 5) ? sb[sent] : 8'h00;
      #1;
      if (out_valid && !out_ready) begin
        check_val("stall_in_ready", in_ready, 0);
        if (was_stall) check_val("stall_hold", out, held);
        held = out;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        check_val("stream_out", out, so[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    check_val("stream_count", got, 5);
    check_val("stream_sent", sent, 5);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1 check_val("stream_drained", out_valid, 0);
  endtask

  task automatic reset_flight_test;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 8'h38;
      b        = 8'h38;
      #1 check_val("flight_accept", in_ready, 1);
      @(negedge clk);
    end
    check_val("flight_out_valid", out_valid, 1);
    // keep offering an operand during reset; it must be discarded too
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check_val("flight_rst_valid", out_valid, 0);
    check_val("flight_rst_out", out, 0);
    check_val("flight_rst_ovf", ovf, 0);
    check_val("flight_rst_unf", unf, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("flight_no_result", out_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = 8'h38;
    b         = 8'h38;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out", out, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_unf", unf, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1 check_val("post_rst_in_ready", in_ready, 1);

    run_vec("sq15",    8'h38, 8'h38, 8'h42, 1'b0, 1'b0);
`ifdef FP_MULT_ROUND_EN
    run_vec("rnd3b",   8'h3B, 8'h3B, 8'h47, 1'b0, 1'b0);
    run_vec("tie_odd", 8'h31, 8'h38, 8'h3A, 1'b0, 1'b0);
    run_vec("rcarry",  8'h37, 8'h36, 8'h40, 1'b0, 1'b0);
    run_vec("rc_ovf",  8'h57, 8'h56, 8'h7F, 1'b1, 1'b0);
`else
    run_vec("rnd3b",   8'h3B, 8'h3B, 8'h46, 1'b0, 1'b0);
    run_vec("tie_odd", 8'h31, 8'h38, 8'h39, 1'b0, 1'b0);
    run_vec("rcarry",  8'h37, 8'h36, 8'h3F, 1'b0, 1'b0);
    run_vec("rc_ovf",  8'h57, 8'h56, 8'h7F, 1'b0, 1'b0);
`endif
    run_vec("tie_even", 8'h33, 8'h38, 8'h3C, 1'b0, 1'b0);
    run_vec("ovf",      8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0);
    run_vec("unf",      8'h10, 8'h10, 8'h00, 1'b0, 1'b1);
    run_vec("neg",      8'hB8, 8'h38, 8'hC2, 1'b0, 1'b0);
    run_vec("zero_neg", 8'h00, 8'hB8, 8'h80, 1'b0, 1'b0);
    run_vec("zero_man", 8'h0F, 8'h38, 8'h00, 1'b0, 1'b0);
    run_vec("emin",     8'h20, 8'h20, 8'h10, 1'b0, 1'b0);
    run_vec("emax",     8'h50, 8'h50, 8'h70, 1'b0, 1'b0);

    stream_test();
    reset_flight_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
